// File: rtl/frame_cfg_pkg.sv
// Shared constants and state type for the fabric configuration loader.
package frame_cfg_pkg;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

  // Address word layout: column in the upper half, frame in the lower half
  localparam int COL_MSB = 31;
  localparam int COL_LSB = 16;
  localparam int FRM_MSB = 15;
  localparam int FRM_LSB = 0;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    ADDR      = 2'd1,
    DATA      = 2'd2,
    STROBE    = 2'd3
  } cfg_state_t;

endpackage

// File: rtl/frame_cfg_row_sr.sv
// NUM_ROWS x WORD_W frame shift register: new word enters row 0, older words move up.
module frame_cfg_row_sr #(
  parameter int NUM_ROWS = 16,
  parameter int WORD_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shift,
  input  logic [WORD_W-1:0]          din,
  output logic [NUM_ROWS*WORD_W-1:0] rows
);

  logic [NUM_ROWS-1:0][WORD_W-1:0] row_q;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic [WORD_W-1:0] nxt;
    logic [WORD_W-1:0] q;
    if (r == 0) begin : g_head
      assign nxt = din;
    end else begin : g_tail
      assign nxt = row_q[r-1];
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)     q <= '0;
      else if (shift) q <= nxt;
    assign row_q[r] = q;
  end

  assign rows = row_q;

endmodule

// File: rtl/frame_cfg_loader.sv
// Bitstream-to-frame configuration loader: sync/desync framing, address decode, one-hot strobe.
// Optional FRAME_CHECKSUM_EN adds a trailing checksum word per frame and the err_chk port.
module frame_cfg_loader
  import frame_cfg_pkg::*;
#(
  parameter int NUM_ROWS       = 16,
  parameter int NUM_COLS       = 10,
  parameter int FRAMES_PER_COL = 20,
  parameter int WORD_W         = 32
) (
  input  logic                                CLK,
  input  logic                                resetn,
  input  logic                                in_valid,
  input  logic [WORD_W-1:0]                   in_data,
  output logic                                in_ready,
  output logic [NUM_ROWS*WORD_W-1:0]          FrameData,
  output logic [NUM_COLS*FRAMES_PER_COL-1:0]  FrameStrobe,
  output logic                                cfg_active,
  output logic                                err_addr,
  input  logic                                err_clr,
`ifdef FRAME_CHECKSUM_EN
  output logic                                err_chk,
`endif
  output logic [15:0]                         frames_done
);

  localparam int NSTB   = NUM_COLS * FRAMES_PER_COL;
  localparam int SIDX_W = $clog2(NSTB);
  localparam int CNT_W  = $clog2(NUM_ROWS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NUM_ROWS - 1);

  cfg_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              bad;
  logic [SIDX_W-1:0] sidx;
  logic [NSTB-1:0]   strobe_hot;
  logic              accept;
  logic              shift;
  logic              addr_bad;
  logic [SIDX_W-1:0] sidx_d;

  assign accept   = in_valid & in_ready;
  assign addr_bad = (in_data[COL_MSB:COL_LSB] >= 16'(NUM_COLS)) ||
                    (in_data[FRM_MSB:FRM_LSB] >= 16'(FRAMES_PER_COL));
  assign sidx_d   = SIDX_W'(32'(in_data[COL_MSB:COL_LSB]) * 32'(FRAMES_PER_COL) +
                            32'(in_data[FRM_MSB:FRM_LSB]));

`ifdef FRAME_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
  // The checksum word arrives at cnt == NUM_ROWS and must not disturb FrameData
  assign shift = accept && (state == DATA) && (cnt != CNT_W'(NUM_ROWS));
`else
  assign shift = accept && (state == DATA);
`endif

  always_comb begin
    strobe_hot = '0;
    for (int i = 0; i < NSTB; i++) strobe_hot[i] = (sidx == SIDX_W'(i));
  end

  frame_cfg_row_sr #(.NUM_ROWS(NUM_ROWS), .WORD_W(WORD_W)) u_row_sr (
    .clk   (CLK),
    .rst_n (resetn),
    .shift (shift),
    .din   (in_data),
    .rows  (FrameData)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= SYNC_WAIT;
      in_ready    <= 1'b1;
      cfg_active  <= 1'b0;
      FrameStrobe <= '0;
      frames_done <= '0;
      err_addr    <= 1'b0;
      cnt         <= '0;
      bad         <= 1'b0;
      sidx        <= '0;
`ifdef FRAME_CHECKSUM_EN
      err_chk     <= 1'b0;
      sum         <= '0;
`endif
    end else begin
      FrameStrobe <= '0;
      if (err_clr) err_addr <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      if (err_clr) err_chk <= 1'b0;
`endif
      case (state)
        SYNC_WAIT:
          if (accept && in_data == SYNC_WORD) begin
            state      <= ADDR;
            cfg_active <= 1'b1;
          end
        ADDR:
          if (accept) begin
            if (in_data == DESYNC_WORD) begin
              state      <= SYNC_WAIT;
              cfg_active <= 1'b0;
            end else begin
              state <= DATA;
              cnt   <= '0;
              bad   <= addr_bad;
              sidx  <= sidx_d;
              if (addr_bad) err_addr <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
              sum   <= in_data;
`endif
            end
          end
        DATA:
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
`ifdef FRAME_CHECKSUM_EN
            sum <= sum + in_data;
            if (cnt == CNT_W'(NUM_ROWS)) begin
              if (bad) begin
                state <= ADDR;
              end else if (in_data != sum) begin
                err_chk <= 1'b1;
                state   <= ADDR;
              end else begin
                state       <= STROBE;
                in_ready    <= 1'b0;
                FrameStrobe <= strobe_hot;
              end
            end
`else
            if (cnt == LAST_DATA) begin
              if (bad) begin
                state <= ADDR;
              end else begin
                state       <= STROBE;
                in_ready    <= 1'b0;
                FrameStrobe <= strobe_hot;
              end
            end
`endif
          end
        STROBE: begin
          state       <= ADDR;
          in_ready    <= 1'b1;
          frames_done <= frames_done + 16'd1;
        end
        default: state <= SYNC_WAIT;
      endcase
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic unused_last;
  assign unused_last = ^LAST_DATA;
`endif

endmodule

// File: tb/tb_frame_cfg_loader.sv
// Directed + randomized bench for frame_cfg_loader with a frame-level reference model.
module tb_frame_cfg_loader;

  logic         CLK;
  logic         resetn;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [511:0] FrameData;
  logic [199:0] FrameStrobe;
  logic         cfg_active;
  logic         err_addr;
  logic         err_clr;
  logic [15:0]  frames_done;
`ifdef FRAME_CHECKSUM_EN
  logic         err_chk;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_done = '0;
  logic        exp_err  = 1'b0;
  logic        exp_chk  = 1'b0;

  frame_cfg_loader dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .cfg_active  (cfg_active),
    .err_addr    (err_addr),
    .err_clr     (err_clr),
`ifdef FRAME_CHECKSUM_EN
    .err_chk     (err_chk),
`endif
    .frames_done (frames_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one word and wait (bounded) until it is accepted; n = cycles taken.
  task automatic send(input logic [31:0] w, output int n);
    logic rdy;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      rdy = in_ready;
      @(posedge CLK); #1;
      n++;
    end while (!rdy && n < 8);
    in_valid = 1'b0;
    chk("accept_timeout", 512'(rdy), 512'(1'b1));
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge CLK); #1;
    err_clr = 1'b0;
    exp_err = 1'b0;
    exp_chk = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_strobe_clr"}, 512'(FrameStrobe), 512'(0));
    chk({tag, "_ready"},      512'(in_ready),    512'(1'b1));
    chk({tag, "_done"},       512'(frames_done), 512'(exp_done));
    chk({tag, "_err_addr"},   512'(err_addr),    512'(exp_err));
`ifdef FRAME_CHECKSUM_EN
    chk({tag, "_err_chk"},    512'(err_chk),     512'(exp_chk));
`endif
  endtask

  // Full frame while synchronised; model derives expected strobe/rows from the address and data.
  task automatic do_frame(input string tag, input logic [15:0] col, input logic [15:0] frm,
                          input bit seq, input bit chk_bad);
    logic [31:0]  d[16];
    logic [31:0]  s;
    logic [511:0] ed;
    logic [199:0] es;
    bit           addr_ok, ok;
    int           n;
    s = {col, frm};
    for (int k = 0; k < 16; k++) begin
      d[k] = seq ? 32'(k) : $urandom;
      s += d[k];
    end
    addr_ok = (col < 16'd10) && (frm < 16'd20);
    ok = addr_ok;
    if (!addr_ok) exp_err = 1'b1;
    send({col, frm}, n);
    for (int k = 0; k < 16; k++) send(d[k], n);
`ifdef FRAME_CHECKSUM_EN
    send(s + (chk_bad ? 32'd1 : 32'd0), n);
    if (addr_ok && chk_bad) begin
      ok = 1'b0;
      exp_chk = 1'b1;
    end
`else
    if (chk_bad) s = 32'd0;
`endif
    for (int r = 0; r < 16; r++) ed[32*r +: 32] = d[15-r];
    es = '0;
    if (ok) es[int'(col) * 20 + int'(frm)] = 1'b1;
    chk({tag, "_strobe"}, 512'(FrameStrobe), 512'(es));
    chk({tag, "_rows"},   FrameData,         ed);
    chk({tag, "_ready_strobe"}, 512'(in_ready), 512'(!ok));
    @(posedge CLK); #1;
    if (ok) exp_done++;
    chk({tag, "_rows_hold"}, FrameData, ed);
    check_status(tag);
  endtask

  initial begin
    int n;
    logic [511:0] hold;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_active", 512'(cfg_active), 512'(0));
    chk("rst_data",   FrameData,        512'(0));
    check_status("rst");
    resetn = 1'b1;

    // 1: junk before sync is dropped
    send(32'h1234_5678, n);
    chk("t1_pre_active", 512'(cfg_active), 512'(0));
    send(32'hFAB0_FAB1, n);
    chk("t1_active", 512'(cfg_active), 512'(1));
    chk("t1_strobe", 512'(FrameStrobe), 512'(0));
    chk("t1_data",   FrameData, 512'(0));

    // 2: sequential data frame at col 3 / frame 5 -> strobe bit 65
    do_frame("t2", 16'd3, 16'd5, 1'b1, 1'b0);
    chk("t2_row15", 512'(FrameData[511:480]), 512'(0));
    chk("t2_row0",  512'(FrameData[31:0]),    512'(15));

    // 3: out-of-range column, then a good frame, then clear
    do_frame("t3_bad", 16'd10, 16'd0, 1'b0, 1'b0);
    do_frame("t3_good", 16'd9, 16'd19, 1'b0, 1'b0);
    pulse_clr();
    chk("t3_clr", 512'(err_addr), 512'(0));
    // Set and clear in the same cycle: set wins
    err_clr = 1'b1;
    send(32'h000B_0000, n);
    err_clr = 1'b0;
    exp_err = 1'b1;
    chk("t3_set_wins", 512'(err_addr), 512'(1));
    for (int k = 0; k < 16; k++) send($urandom, n);
`ifdef FRAME_CHECKSUM_EN
    send($urandom, n);
`endif
    @(posedge CLK); #1;
    check_status("t3_tail");
    pulse_clr();

    // 4: desync, then a would-be frame is ignored
    send(32'hFAB0_FAB0, n);
    chk("t4_active", 512'(cfg_active), 512'(0));
    hold = FrameData;
    send(32'h0000_0000, n);
    for (int k = 0; k < 17; k++) send($urandom, n);
    chk("t4_hold", FrameData, hold);
    chk("t4_active2", 512'(cfg_active), 512'(0));
    check_status("t4");
    send(32'hFAB0_FAB1, n);

    // 5: next word held valid across STROBE takes two cycles
    send(32'h0002_0001, n);
    for (int k = 0; k < 16; k++) send(32'(k * 3), n);
`ifdef FRAME_CHECKSUM_EN
    send(32'h0002_0001 + 32'd360, n);
`endif
    chk("t5_strobe", 512'(FrameStrobe[41]), 512'(1));
    chk("t5_ready0", 512'(in_ready), 512'(0));
    send(32'hFAB0_FAB0, n);
    exp_done++;
    chk("t5_wait", 512'(n), 512'(2));
    chk("t5_desync", 512'(cfg_active), 512'(0));
    check_status("t5");

    // 5b: reset after 7 data words
    send(32'hFAB0_FAB1, n);
    send(32'h0001_0001, n);
    for (int k = 0; k < 7; k++) send($urandom, n);
    resetn = 1'b0;
    #2;
    exp_done = '0;
    exp_err  = 1'b0;
    exp_chk  = 1'b0;
    chk("t5r_active", 512'(cfg_active), 512'(0));
    chk("t5r_data",   FrameData, 512'(0));
    check_status("t5r");
    @(posedge CLK); #1;
    resetn = 1'b1;
    send(32'h0001_0001, n);
    for (int k = 0; k < 17; k++) send($urandom, n);
    chk("t5r_nosync", 512'(cfg_active), 512'(0));
    check_status("t5r_post");
    send(32'hFAB0_FAB1, n);

`ifdef FRAME_CHECKSUM_EN
    // 6: checksum good then off-by-one
    do_frame("t6_ok",  16'd1, 16'd2, 1'b0, 1'b0);
    do_frame("t6_bad", 16'd1, 16'd2, 1'b0, 1'b1);
    pulse_clr();
    check_status("t6_clr");
`endif

    // Randomized frames, including out-of-range addresses
    for (int i = 0; i < 24; i++) begin
      logic [15:0] c, f;
      bit cb;
      c  = 16'($urandom_range(0, 11));
      f  = 16'($urandom_range(0, 21));
      cb = (c < 16'd10 && f < 16'd20) ? bit'($urandom_range(0, 1)) : 1'b0;
      do_frame("rnd", c, f, 1'b0, cb);
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
